// File: rtl/fetch_pkg.sv
// Shared constants, entry type and sizing helper for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered circular buffer for fetched {pc, instr} words; head is read from storage, no fall-through.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head_data,
    output logic [occ_w(DEPTH)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = occ_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetch front end: credit-limited issue to a pipelined memory,
// in-flight tracking with wrong-path kill on redirect, and a decoupling queue toward decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    halt,
    input  logic                    flush,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    mem_read_en,
    output logic [ADDR_W-1:0]       mem_read_addr,
    input  logic [DATA_W-1:0]       mem_read_data,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]       out_pc,
    output logic [occ_w(DEPTH)-1:0] occupancy
);

    localparam int unsigned CW = occ_w(DEPTH);
    localparam int unsigned EW = ADDR_W + DATA_W;

    logic [CW-1:0]     count;
    logic [EW-1:0]     head_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [MEM_LAT-1:0] slot_v;
    logic [ADDR_W-1:0] slot_pc [MEM_LAT];
    int unsigned       inflight;
    logic              has_head;
    logic              pop;
    logic              push;
    logic              clear;
    logic              issue;

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 32'(slot_v[i]);
        end
    end

    assign has_head  = (count != '0);
    assign out_valid = has_head && !halt && !rst;
    assign pop       = out_valid && !stall && !flush;
    assign addr      = flush ? redirect_pc : pc;
    // Credits: queued + in flight - leaving must stay below DEPTH, so a return always finds room.
    assign issue     = !rst && !halt &&
                       (flush || ((32'(count) + inflight - 32'(pop)) < DEPTH));
    assign push      = slot_v[MEM_LAT-1] && !halt && !flush;
    assign clear     = flush && !halt;

    assign mem_read_en   = issue;
    assign mem_read_addr = addr;
    assign out_pc        = (has_head && !rst) ? head_data[EW-1:DATA_W] : '0;
    assign out_instr     = (has_head && !rst) ? head_data[DATA_W-1:0]  : '0;
    assign occupancy     = rst ? '0 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (issue) begin
            pc <= addr + ADDR_W'(INSTR_BYTES);
        end else if (flush) begin
            pc <= redirect_pc;
        end
    end

    // Slots keep shifting during halt with nothing entering, so reads already in flight
    // drain out and their data is dropped rather than surfacing after the halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v <= '0;
        end else begin
            slot_v[0] <= issue;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                slot_v[i] <= clear ? 1'b0 : slot_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        slot_pc[0] <= addr;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            slot_pc[i] <= slot_pc[i-1];
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data ({slot_pc[MEM_LAT-1], mem_read_data}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CW'(DEPTH)) && !pop));

endmodule
